// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute/writeback sideband bundle for the pipeline sequencing controller.
// Latency: n/a (wires only).
// Backpressure: carries the stall vector itself; no handshake of its own.
//
// Ports (master = pipeline side, slave = pipe_hazard_ctrl):
//   decode : id_valid, id_reg1_read/addr, id_reg2_read/addr, id_wreg, id_wd
//   execute: ex_stallreq, branch_flush
//   wb     : wb_wreg, wb_wd
//   control: stall[5:0] (PC,IF,ID,EX,MEM,WB), flush, issue
//   status : busy_o, stall_cycles, timeout_err, state (RUN/HAZ/EXW/FLUSH)
interface pipe_hazard_ctrl_if #(
    parameter int REG_NUM = 16,
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 16
);
    logic              id_valid;
    logic              id_reg1_read;
    logic [ADDR_W-1:0] id_reg1_addr;
    logic              id_reg2_read;
    logic [ADDR_W-1:0] id_reg2_addr;
    logic              id_wreg;
    logic [ADDR_W-1:0] id_wd;
    logic              ex_stallreq;
    logic              branch_flush;
    logic              wb_wreg;
    logic [ADDR_W-1:0] wb_wd;

    logic [5:0]         stall;
    logic               flush;
    logic               issue;
    logic [REG_NUM-1:0] busy_o;
    logic [CNT_W-1:0]   stall_cycles;
    logic               timeout_err;
    logic [1:0]         state;

    modport master (
        output id_valid, id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr,
               id_wreg, id_wd, ex_stallreq, branch_flush, wb_wreg, wb_wd,
        input  stall, flush, issue, busy_o, stall_cycles, timeout_err, state
    );

    modport slave (
        input  id_valid, id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr,
               id_wreg, id_wd, ex_stallreq, branch_flush, wb_wreg, wb_wd,
        output stall, flush, issue, busy_o, stall_cycles, timeout_err, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: register scoreboard + RAW/WAW hazard detect, stall/flush merge, stall watchdog.
// Latency: stall/flush/issue are combinational in the same cycle; scoreboard and counters update on the rising edge.
// Backpressure: ex_stallreq holds PC..EX, a hazard holds PC..ID (bubble into EX); a flush deferred by ex_stallreq is replayed once it drops.
//
// Ports: clk (rising edge), rst (async, active low), bus (pipe_hazard_ctrl_if.slave, see interface header).
module pipe_hazard_ctrl #(
    parameter int REG_NUM     = 16,
    parameter int ADDR_W      = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int                WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]   TO_MAX = WD_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_EXW   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t             r_state;
    logic [REG_NUM-1:0] r_busy;
    logic               r_flush_pend;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic [WD_W-1:0]    r_consec;
    logic               r_timeout;

    logic [REG_NUM-1:0] w_wb_clr;
    logic [REG_NUM-1:0] w_id_set;
    logic [REG_NUM-1:0] w_busy_eff;
    logic               w_haz;
    logic               w_flush_req;
    logic [5:0]         w_stall;
    logic               w_flush;
    logic               w_issue;
    state_t             w_state_nxt;

    always_comb begin
        w_wb_clr = '0;
        if (bus.wb_wreg) w_wb_clr[bus.wb_wd] = 1'b1;
    end

    always_comb begin
        w_id_set = '0;
        if (w_issue && bus.id_wreg) w_id_set[bus.id_wd] = 1'b1;
    end

    // A same-cycle writeback releases its register before the hazard check,
    // so a dependent instruction issues without an extra bubble.
    assign w_busy_eff  = r_busy & ~w_wb_clr;
    assign w_haz       = bus.id_valid &
                         ((bus.id_reg1_read & w_busy_eff[bus.id_reg1_addr]) |
                          (bus.id_reg2_read & w_busy_eff[bus.id_reg2_addr]) |
                          (bus.id_wreg      & w_busy_eff[bus.id_wd]));
    assign w_flush_req = bus.branch_flush | r_flush_pend;

    always_comb begin
        w_stall = '0;
        w_flush = 1'b0;
        w_issue = 1'b0;
        if (rst) begin
            if (bus.ex_stallreq) begin
                w_stall = 6'b001111;
            end else if (w_flush_req) begin
                w_flush = 1'b1;
            end else if (w_haz) begin
                w_stall = 6'b000111;
            end else begin
                w_issue = bus.id_valid;
            end
        end
    end

    always_comb begin
        if (bus.ex_stallreq)  w_state_nxt = ST_EXW;
        else if (w_flush)     w_state_nxt = ST_FLUSH;
        else if (w_haz)       w_state_nxt = ST_HAZ;
        else                  w_state_nxt = ST_RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_RUN;
            r_busy         <= '0;
            r_flush_pend   <= 1'b0;
            r_stall_cycles <= '0;
            r_consec       <= '0;
            r_timeout      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Set is OR-ed after the clear so a same-register issue wins.
            r_busy <= (r_busy & ~w_wb_clr) | w_id_set;

            // A branch that lands under ex_stallreq is remembered and
            // delivered on the first non-stalled cycle.
            if (w_flush)
                r_flush_pend <= 1'b0;
            else if (bus.branch_flush && bus.ex_stallreq)
                r_flush_pend <= 1'b1;

            if (w_stall != '0) begin
                if (r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
                if (r_consec != TO_MAX)   r_consec       <= r_consec + 1'b1;
                if (r_consec == TO_MAX - 1'b1) r_timeout <= 1'b1;
            end else begin
                r_consec <= '0;
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_flush;
    assign bus.issue        = w_issue;
    assign bus.busy_o       = r_busy;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.timeout_err  = r_timeout;
    assign bus.state        = r_state;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed stimulus pushes expected outputs, a negedge monitor pops and compares.
// Latency: one expectation per clock cycle, checked at the falling edge of that cycle.
// Backpressure: none; the driver never waits on the DUT except a bounded queue drain at the end.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.REG_NUM(16), .ADDR_W(4), .CNT_W(16)) bus ();

    pipe_hazard_ctrl #(
        .REG_NUM(16), .ADDR_W(4), .CNT_W(16), .TIMEOUT_CYC(255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [5:0]  st;
        logic        fl;
        logic        is;
        logic [15:0] bz;
        logic [15:0] sc;
        logic        tm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    exp_t e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, "stall", 32'(bus.stall),        32'(e.st));
            chk(e.nm, "flush", 32'(bus.flush),        32'(e.fl));
            chk(e.nm, "issue", 32'(bus.issue),        32'(e.is));
            chk(e.nm, "busy",  32'(bus.busy_o),       32'(e.bz));
            chk(e.nm, "scyc",  32'(bus.stall_cycles), 32'(e.sc));
            chk(e.nm, "tmo",   32'(bus.timeout_err),  32'(e.tm));
        end
    end

    task automatic clr();
        bus.id_valid     = 1'b0;
        bus.id_reg1_read = 1'b0;
        bus.id_reg1_addr = '0;
        bus.id_reg2_read = 1'b0;
        bus.id_reg2_addr = '0;
        bus.id_wreg      = 1'b0;
        bus.id_wd        = '0;
        bus.ex_stallreq  = 1'b0;
        bus.branch_flush = 1'b0;
        bus.wb_wreg      = 1'b0;
        bus.wb_wd        = '0;
    endtask

    // Push the expectation for the current input set, then advance one cycle.
    task automatic cyc(input string nm, input logic [5:0] st, input logic fl, input logic is,
                       input logic [15:0] bz, input logic [15:0] sc, input logic tm);
        exp_t x;
        x.nm = nm; x.st = st; x.fl = fl; x.is = is; x.bz = bz; x.sc = sc; x.tm = tm;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 6'h00, 0, 0, 16'h0000, 16'd0, 0);
        rst = 1'b1;
        cyc("idle", 6'h00, 0, 0, 16'h0000, 16'd0, 0);

        // RAW on r3, released by a same-cycle writeback
        bus.id_valid = 1; bus.id_wreg = 1; bus.id_wd = 4'd3;
        cyc("iss_r3", 6'h00, 0, 1, 16'h0000, 16'd0, 0);
        clr(); bus.id_valid = 1; bus.id_reg1_read = 1; bus.id_reg1_addr = 4'd3;
        cyc("raw_r3", 6'h07, 0, 0, 16'h0008, 16'd0, 0);
        bus.wb_wreg = 1; bus.wb_wd = 4'd3;
        cyc("wb_bypass", 6'h00, 0, 1, 16'h0008, 16'd1, 0);
        clr();
        cyc("idle2", 6'h00, 0, 0, 16'h0000, 16'd1, 0);

        // ex_stallreq over a pending hazard on r7
        bus.id_valid = 1; bus.id_wreg = 1; bus.id_wd = 4'd7;
        cyc("iss_r7", 6'h00, 0, 1, 16'h0000, 16'd1, 0);
        clr(); bus.id_valid = 1; bus.id_reg2_read = 1; bus.id_reg2_addr = 4'd7; bus.ex_stallreq = 1;
        for (int i = 0; i < 4; i++)
            cyc("exs_haz", 6'h0F, 0, 0, 16'h0080, 16'(1 + i), 0);
        bus.ex_stallreq = 0;
        cyc("haz_a", 6'h07, 0, 0, 16'h0080, 16'd5, 0);
        cyc("haz_b", 6'h07, 0, 0, 16'h0080, 16'd6, 0);
        bus.wb_wreg = 1; bus.wb_wd = 4'd7;
        cyc("wb7", 6'h00, 0, 1, 16'h0080, 16'd7, 0);

        // WAW on r9
        clr(); bus.id_valid = 1; bus.id_wreg = 1; bus.id_wd = 4'd9;
        cyc("iss_r9", 6'h00, 0, 1, 16'h0000, 16'd7, 0);
        cyc("waw_r9", 6'h07, 0, 0, 16'h0200, 16'd7, 0);
        clr(); bus.wb_wreg = 1; bus.wb_wd = 4'd9;
        cyc("wb9", 6'h00, 0, 0, 16'h0200, 16'd8, 0);

        // Branch under ex_stallreq is deferred, then flushes exactly once
        clr(); bus.ex_stallreq = 1; bus.branch_flush = 1;
        cyc("bf_exs", 6'h0F, 0, 0, 16'h0000, 16'd8, 0);
        bus.branch_flush = 0;
        cyc("exs_hold", 6'h0F, 0, 0, 16'h0000, 16'd9, 0);
        bus.ex_stallreq = 0; bus.id_valid = 1;
        cyc("pend_flush", 6'h00, 1, 0, 16'h0000, 16'd10, 0);
        cyc("post_flush", 6'h00, 0, 1, 16'h0000, 16'd10, 0);
        clr(); bus.branch_flush = 1;
        cyc("bf_direct", 6'h00, 1, 0, 16'h0000, 16'd10, 0);
        clr();
        cyc("bf_gone", 6'h00, 0, 0, 16'h0000, 16'd10, 0);

        // Same-register set and clear: set wins
        bus.id_valid = 1; bus.id_wreg = 1; bus.id_wd = 4'd5; bus.wb_wreg = 1; bus.wb_wd = 4'd5;
        cyc("setclr5", 6'h00, 0, 1, 16'h0000, 16'd10, 0);
        clr();
        cyc("busy5", 6'h00, 0, 0, 16'h0020, 16'd10, 0);
        bus.wb_wreg = 1; bus.wb_wd = 4'd5;
        cyc("wb5", 6'h00, 0, 0, 16'h0020, 16'd10, 0);

        // Watchdog: set on the 255th consecutive stalled edge, then sticky
        clr(); bus.ex_stallreq = 1;
        for (int i = 0; i < 255; i++)
            cyc("tmo_run", 6'h0F, 0, 0, 16'h0000, 16'(10 + i), 0);
        bus.ex_stallreq = 0;
        cyc("tmo_set", 6'h00, 0, 0, 16'h0000, 16'd265, 1);
        cyc("tmo_sticky", 6'h00, 0, 0, 16'h0000, 16'd265, 1);

        // Build busy = 00F0 and a pending flush, then reset mid-stall
        for (int i = 0; i < 4; i++) begin
            clr(); bus.id_valid = 1; bus.id_wreg = 1; bus.id_wd = 4'(4 + i);
            cyc("fill", 6'h00, 0, 1, 16'h00F0 & ((16'h0010 << i) - 16'h0010), 16'd265, 1);
        end
        clr(); bus.ex_stallreq = 1; bus.branch_flush = 1;
        cyc("pre_rst", 6'h0F, 0, 0, 16'h00F0, 16'd265, 1);
        bus.branch_flush = 0;
        rst = 1'b0;
        cyc("rst_mid", 6'h00, 0, 0, 16'h0000, 16'd0, 0);
        rst = 1'b1;
        clr();
        cyc("no_replay", 6'h00, 0, 0, 16'h0000, 16'd0, 0);
        cyc("no_replay2", 6'h00, 0, 0, 16'h0000, 16'd0, 0);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
